// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the FIFO-bank arbiter: sizes, state encoding, helpers.
package fifo_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned NUM_FIFOS = 8;
  localparam int unsigned DEST_W    = 2;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // One-hot strobe for a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [DEST_W-1:0] idx);
    port_onehot      = '0;
    port_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// Signals between the arbiter and the eight-FIFO bank (four inputs, four outputs).
interface fifo_arbiter_if
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned PTR_L     = 5
);

  logic [NUM_PORTS-1:0]           in_empty;
  logic [NUM_PORTS*WORD_SIZE-1:0] in_data;
  logic [NUM_PORTS-1:0]           out_almost_full;
  logic [NUM_FIFOS-1:0]           fifo_error;
  logic [NUM_PORTS-1:0]           in_rd;
  logic [NUM_PORTS-1:0]           out_wr;
  logic [WORD_SIZE-1:0]           out_data;
  logic [PTR_L-1:0]               full_threshold;
  logic [PTR_L-1:0]               empty_threshold;

  modport master (
    input  in_empty, in_data, out_almost_full, fifo_error,
    output in_rd, out_wr, out_data, full_threshold, empty_threshold
  );

  modport slave (
    output in_empty, in_data, out_almost_full, fifo_error,
    input  in_rd, out_wr, out_data, full_threshold, empty_threshold
  );

endinterface

// File: rtl/fifo_arbiter_rr_select.sv
// Rotate-priority encoder: first eligible port after last_grant, wrapping mod 4.
module fifo_arbiter_rr_select
  import fifo_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic [DEST_W-1:0]    i_last_grant,
  output logic                 o_grant_valid,
  output logic [DEST_W-1:0]    o_grant_idx
);

  // Scan from farthest to nearest so the nearest eligible port wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (i_eligible[DEST_W'(int'(i_last_grant) + k)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = DEST_W'(int'(i_last_grant) + k);
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// FIFO bank controller: config FSM, round-robin input pop, registered output push.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned PTR_L     = 5,
  parameter int unsigned DEF_FULL  = 3,
  parameter int unsigned DEF_EMPTY = 1
)(
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [PTR_L-1:0]   full_threshold_in,
  input  logic [PTR_L-1:0]   empty_threshold_in,
  fifo_arbiter_if.master     bank,
  output logic [STATE_W-1:0] state,
  output logic               idle
);

  state_e                r_state;
  state_e                w_next_state;
  logic [DEST_W-1:0]     r_last_grant;
  logic [NUM_PORTS-1:0]  w_eligible;
  logic                  w_any_error;
  logic                  w_grant_valid;
  logic                  w_grant_en;
  logic [DEST_W-1:0]     w_grant_idx;
  logic [DEST_W-1:0]     w_grant_dest;
  logic [WORD_SIZE-1:0]  w_grant_word;

  assign w_any_error  = |bank.fifo_error;
  assign w_grant_word = bank.in_data[32'(w_grant_idx) * WORD_SIZE +: WORD_SIZE];
  assign w_grant_dest = w_grant_word[WORD_SIZE-1 -: DEST_W];
  assign state        = r_state;

  // A port may be served only if it has data and its destination can accept it.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_eligible[i] = ~bank.in_empty[i] &
        ~bank.out_almost_full[bank.in_data[i*WORD_SIZE + WORD_SIZE - DEST_W +: DEST_W]];
    end
  end

  fifo_arbiter_rr_select u_rr_select (
    .i_eligible    (w_eligible),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Next-state and grant enable; an error in the same cycle kills the pop.
  always_comb begin
    w_next_state = r_state;
    w_grant_en   = 1'b0;
    case (r_state)
      ST_RESET:  w_next_state = ST_INIT;
      ST_INIT:   if (!init) w_next_state = ST_IDLE;
      ST_IDLE: begin
        if (w_any_error)          w_next_state = ST_ERROR;
        else if (init)            w_next_state = ST_INIT;
        else if (!(&bank.in_empty)) w_next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_any_error) begin
          w_next_state = ST_ERROR;
        end else begin
          w_grant_en = w_grant_valid;
          if (init)                 w_next_state = ST_INIT;
          else if (&bank.in_empty)  w_next_state = ST_IDLE;
        end
      end
      ST_ERROR:  w_next_state = ST_ERROR;
      default:   w_next_state = ST_RESET;
    endcase
  end

  // Pop strobe is combinational so the FWFT head is consumed in the grant cycle.
  always_comb begin
    bank.in_rd = '0;
    if (w_grant_en) bank.in_rd = port_onehot(w_grant_idx);
  end

  // State, idle flag and round-robin pointer.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= ST_RESET;
      idle         <= 1'b0;
      r_last_grant <= DEST_W'(NUM_PORTS - 1);
    end else begin
      r_state <= w_next_state;
      idle    <= (w_next_state == ST_IDLE);
      if (w_grant_en) r_last_grant <= w_grant_idx;
    end
  end

  // Output push one cycle after the pop; data holds when nothing is written.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bank.out_wr   <= '0;
      bank.out_data <= '0;
    end else if (w_grant_en) begin
      bank.out_wr   <= port_onehot(w_grant_dest);
      bank.out_data <= w_grant_word;
    end else begin
      bank.out_wr   <= '0;
    end
  end

  // Thresholds track the config inputs while in INIT.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bank.full_threshold  <= PTR_L'(DEF_FULL);
      bank.empty_threshold <= PTR_L'(DEF_EMPTY);
    end else if (r_state == ST_INIT) begin
      bank.full_threshold  <= full_threshold_in;
      bank.empty_threshold <= empty_threshold_in;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: config, round-robin, backpressure, error, reset.
module tb_fifo_arbiter;

  localparam int unsigned WS = 6;
  localparam int unsigned PL = 5;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic [PL-1:0] fti;
  logic [PL-1:0] eti;
  logic [2:0]    state;
  logic          idle;

  fifo_arbiter_if #(.WORD_SIZE(WS), .PTR_L(PL)) bank ();

  fifo_arbiter #(
    .WORD_SIZE(WS), .PTR_L(PL), .DEF_FULL(3), .DEF_EMPTY(1)
  ) dut (
    .clk                (clk),
    .reset_L            (reset_L),
    .init               (init),
    .full_threshold_in  (fti),
    .empty_threshold_in (eti),
    .bank               (bank),
    .state              (state),
    .idle               (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  empty;
    logic [23:0] data;
    logic [3:0]  afull;
    logic [7:0]  err;
    logic        init;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic [5:0]  exp_data;
    logic [2:0]  exp_state;
    logic        exp_idle;
  } vec_t;

  vec_t vecs [16];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input logic [5:0] p3, input logic [5:0] p2,
                                     input logic [5:0] p1, input logic [5:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  function automatic vec_t mk(input logic [3:0] e, input logic [23:0] d, input logic [3:0] af,
                              input logic [7:0] er, input logic in, input logic [3:0] rd,
                              input logic [3:0] wr, input logic [5:0] od, input logic [2:0] st,
                              input logic id);
    vec_t v;
    v.empty = e; v.data = d; v.afull = af; v.err = er; v.init = in;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_data = od; v.exp_state = st; v.exp_idle = id;
    return v;
  endfunction

  initial begin
    logic [23:0] d_rr, d_af, d_er, d_rs;
    d_rr = pk(6'h23, 6'h22, 6'h21, 6'h20);
    d_af = pk(6'h00, 6'h00, 6'h35, 6'h00);
    d_er = pk(6'h00, 6'h0A, 6'h00, 6'h00);
    d_rs = pk(6'h17, 6'h00, 6'h00, 6'h00);

    //           empty    data  afull   err    init rd       wr       data   st   idle
    vecs[0]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b0000, 4'b0000, 6'h00, 3'd2, 1);
    vecs[1]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b0001, 4'b0000, 6'h00, 3'd3, 0);
    vecs[2]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b0010, 4'b0100, 6'h20, 3'd3, 0);
    vecs[3]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b0100, 4'b0100, 6'h21, 3'd3, 0);
    vecs[4]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b1000, 4'b0100, 6'h22, 3'd3, 0);
    vecs[5]  = mk(4'b0000, d_rr, 4'b0000, 8'h00, 0, 4'b0001, 4'b0100, 6'h23, 3'd3, 0);
    vecs[6]  = mk(4'b1101, d_af, 4'b1000, 8'h00, 0, 4'b0000, 4'b0100, 6'h20, 3'd3, 0);
    vecs[7]  = mk(4'b1101, d_af, 4'b1000, 8'h00, 0, 4'b0000, 4'b0000, 6'h20, 3'd3, 0);
    vecs[8]  = mk(4'b1101, d_af, 4'b0000, 8'h00, 0, 4'b0010, 4'b0000, 6'h20, 3'd3, 0);
    vecs[9]  = mk(4'b1111, d_af, 4'b0000, 8'h00, 0, 4'b0000, 4'b1000, 6'h35, 3'd3, 0);
    vecs[10] = mk(4'b1111, d_af, 4'b0000, 8'h00, 0, 4'b0000, 4'b0000, 6'h35, 3'd2, 1);
    vecs[11] = mk(4'b1011, d_er, 4'b0000, 8'h00, 0, 4'b0000, 4'b0000, 6'h35, 3'd2, 1);
    vecs[12] = mk(4'b1011, d_er, 4'b0000, 8'h00, 0, 4'b0100, 4'b0000, 6'h35, 3'd3, 0);
    vecs[13] = mk(4'b1011, d_er, 4'b0000, 8'h40, 1, 4'b0000, 4'b0001, 6'h0A, 3'd3, 0);
    vecs[14] = mk(4'b1011, d_er, 4'b0000, 8'h40, 1, 4'b0000, 4'b0000, 6'h0A, 3'd4, 0);
    vecs[15] = mk(4'b1011, d_er, 4'b0000, 8'h00, 0, 4'b0000, 4'b0000, 6'h0A, 3'd4, 0);

    // Reset and configuration sequence.
    reset_L = 1'b0; init = 1'b1; fti = 5'd5; eti = 5'd2;
    bank.in_empty = 4'b1111; bank.in_data = '0;
    bank.out_almost_full = '0; bank.fifo_error = '0;
    @(negedge clk);
    chk("rst_state", -1, 32'(state), 32'd0);
    chk("rst_rd", -1, 32'(bank.in_rd), 32'd0);
    chk("rst_wr", -1, 32'(bank.out_wr), 32'd0);
    chk("rst_data", -1, 32'(bank.out_data), 32'd0);
    chk("rst_idle", -1, 32'(idle), 32'd0);
    chk("rst_fth", -1, 32'(bank.full_threshold), 32'd3);
    chk("rst_eth", -1, 32'(bank.empty_threshold), 32'd1);
    reset_L = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_state_init", -1, 32'(state), 32'd1);
    @(posedge clk); #1; init = 1'b0;
    @(negedge clk);
    chk("cfg_state_init2", -1, 32'(state), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_state_idle", -1, 32'(state), 32'd2);
    chk("cfg_idle", -1, 32'(idle), 32'd1);
    chk("cfg_fth", -1, 32'(bank.full_threshold), 32'd5);
    chk("cfg_eth", -1, 32'(bank.empty_threshold), 32'd2);

    // Table: round-robin, backpressure, drain, error absorption.
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      bank.in_empty = vecs[r].empty; bank.in_data = vecs[r].data;
      bank.out_almost_full = vecs[r].afull; bank.fifo_error = vecs[r].err;
      init = vecs[r].init;
      @(negedge clk);
      chk("in_rd", r, 32'(bank.in_rd), 32'(vecs[r].exp_rd));
      chk("out_wr", r, 32'(bank.out_wr), 32'(vecs[r].exp_wr));
      chk("out_data", r, 32'(bank.out_data), 32'(vecs[r].exp_data));
      chk("state", r, 32'(state), 32'(vecs[r].exp_state));
      chk("idle", r, 32'(idle), 32'(vecs[r].exp_idle));
    end

    // Reset leaves ERROR and restores defaults.
    @(posedge clk); #1; reset_L = 1'b0;
    @(negedge clk);
    chk("err_rst_state", -1, 32'(state), 32'd0);
    chk("err_rst_wr", -1, 32'(bank.out_wr), 32'd0);
    chk("err_rst_fth", -1, 32'(bank.full_threshold), 32'd3);
    chk("err_rst_eth", -1, 32'(bank.empty_threshold), 32'd1);
    reset_L = 1'b1; init = 1'b0; bank.in_empty = 4'b1111; bank.fifo_error = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("re_state_init", -1, 32'(state), 32'd1);
    @(posedge clk); #1;
    bank.in_empty = 4'b0111; bank.in_data = d_rs;
    @(negedge clk);
    chk("re_state_idle", -1, 32'(state), 32'd2);
    chk("re_rd_idle", -1, 32'(bank.in_rd), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("re_state_active", -1, 32'(state), 32'd3);
    chk("re_rd_port3", -1, 32'(bank.in_rd), 32'b1000);

    // Reset while a write is in flight drops it immediately.
    @(posedge clk); #1;
    bank.in_empty = 4'b1111;
    chk("flight_wr", -1, 32'(bank.out_wr), 32'b0010);
    chk("flight_data", -1, 32'(bank.out_data), 32'h17);
    #1; reset_L = 1'b0;
    #1;
    chk("mid_rst_wr", -1, 32'(bank.out_wr), 32'd0);
    chk("mid_rst_data", -1, 32'(bank.out_data), 32'd0);
    chk("mid_rst_state", -1, 32'(state), 32'd0);
    chk("mid_rst_rd", -1, 32'(bank.in_rd), 32'd0);
    chk("mid_rst_fth", -1, 32'(bank.full_threshold), 32'd3);
    chk("mid_rst_eth", -1, 32'(bank.empty_threshold), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Controller and round-robin arbiter for the interconnect device's FIFO bank. It sequences four input FIFOs into four output FIFOs: it pops a word from an input FIFO and steers it to the output FIFO selected by the word's destination field. It also owns the threshold configuration and error supervision for the whole bank. It sits between the input `fifo` instances (read side) and the output `fifo` instances (write side).

## Interface
**Parameters**
- `WORD_SIZE`, 6: word width; bits `[WORD_SIZE-1:WORD_SIZE-2]` are the destination port.
- `PTR_L`, 5: threshold width, matching the FIFO pointer width.
- `DEF_FULL`, 3: `full_threshold` value on reset.
- `DEF_EMPTY`, 1: `empty_threshold` value on reset.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: reset, asynchronous and active-low.
- `init` in 1: request configuration mode.
- `full_threshold_in` in PTR_L: configured almost-full threshold.
- `empty_threshold_in` in PTR_L: configured almost-empty threshold.
- `in_empty` in 4: `fifo_empty` of each input FIFO.
- `in_data` in 4*WORD_SIZE: head word of each input FIFO; port i is at `[i*WORD_SIZE +: WORD_SIZE]`.
- `out_almost_full` in 4: `almost_full` of each output FIFO.
- `fifo_error` in 8: `error` of all eight FIFOs (inputs 0-3, outputs 4-7).
- `in_rd` out 4: pop strobe to the input FIFOs, one-hot or zero.
- `out_wr` out 4: push strobe to the output FIFOs, one-hot or zero.
- `out_data` out WORD_SIZE: shared write data to the output FIFOs.
- `full_threshold` out PTR_L: threshold driven to all FIFOs.
- `empty_threshold` out PTR_L: threshold driven to all FIFOs.
- `state` out 3: current FSM state.
- `idle` out 1: high in IDLE.

## Operation
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET: unconditionally goes to INIT on the first edge after reset deasserts.
- INIT:
  - Loads `full_threshold`/`empty_threshold` from the `*_in` ports every cycle.
  - Goes to IDLE when `init`=0.
- IDLE:
  - `idle`=1.
  - Priority order: any `fifo_error` → ERROR; else `init` → INIT; else any `in_empty`=0 → ACTIVE.
- ACTIVE:
  - Arbitrates every cycle.
  - Same error/init priority as IDLE.
  - Goes to IDLE when all `in_empty`=1.
- ERROR: absorbing; exits only via `reset_L`. All strobes are held at 0.
- Arbitration (ACTIVE only):
  - Port i is eligible iff `in_empty[i]`=0 and `out_almost_full[dest_i]`=0.
  - Round-robin search starts at `last_grant+1` (mod 4).
  - Winner w gets `in_rd[w]`=1 combinationally in the same cycle.
  - `last_grant` updates to w only on a grant.
  - No eligible port: no strobe, `last_grant` unchanged.
- Write: at the clock edge of a grant, `out_data` ← `in_data[w]` and `out_wr` ← one-hot(dest_w). Both are registered and last one cycle. If no grant, `out_wr` ← 0 and `out_data` holds its value.
- Input FIFOs are first-word-fall-through: `in_data` is valid whenever `in_empty`=0.

## Timing
- Reset values (asynchronous):
  - `state`=RESET, `last_grant`=3 so port 0 is served first.
  - `in_rd`=0, `out_wr`=0, `out_data`=0, `idle`=0.
  - Thresholds = `DEF_FULL`/`DEF_EMPTY`.
- Latency: `in_rd` at cycle N produces `out_wr`/`out_data` at cycle N+1.
- Throughput: one word per cycle.
- Backpressure: one write is in flight at any time, so the output FIFO's almost-full threshold must leave at least one free slot. This is the integrator's rule; the block does not check it.
- Simultaneous events:
  - Error together with `init`: ERROR wins.
  - Error while a grant is pending: the combinational `in_rd` is suppressed that cycle.
  - A write registered in the previous cycle still completes.
- Reset mid-transfer: the in-flight `out_wr` is cleared immediately and the word is dropped.
- Wrap: `last_grant` rolls over 3 → 0.

## Structure
- Shared defines file `fifo_arbiter_defs`:
  - State encoding localparams.
  - `DEST_W`=2.
  - Port count 4.
- Sub-module `rr_select`: combinational rotate-priority encoder.
  - Inputs: eligible[3:0], last_grant[1:0].
  - Outputs: grant_valid, grant_idx[1:0].
- Top: FSM, threshold registers, output write register.

## Test plan
- Reset, hold `init`=1 for 2 cycles with `full_threshold_in`=5, `empty_threshold_in`=2, then release → state sequence 0→1→2; thresholds read 5/2; `idle`=1.
- Ports 0-3 all non-empty, all heads with dest=2, no almost_full → `in_rd` sequence 0001, 0010, 0100, 1000, 0001. `out_wr`=0100 each cycle, one cycle later than its `in_rd`.
- Port 1 head=6'b11_0101, `out_almost_full[3]`=1 → no grant to port 1. Deassert almost_full → next cycle `in_rd`=0010; following cycle `out_wr`=1000, `out_data`=6'h35.
- Assert `fifo_error[6]` while ACTIVE with `init`=1 → state=4 next cycle; `in_rd` and `out_wr` stay 0 until `reset_L` pulses low.
- `reset_L` low in the cycle after a grant → `out_wr`=0 immediately; state=0; thresholds return to 3/1.
- All inputs drain during ACTIVE → ACTIVE→IDLE on the cycle after the last `in_empty` rises; `idle`=1.
